// File: rtl/rs_alu_if.sv
// Bundle of the issue port, the two result broadcast buses and the ALU
// dispatch port of the integer ALU reservation station.
interface rs_alu_if #(
    parameter int ROB_W = 4
);
    // issue port
    logic             issue_en;
    logic [ROB_W-1:0] issue_rob_pos;
    logic [6:0]       issue_opcode;
    logic [2:0]       issue_funct3;
    logic             issue_funct7;
    logic             issue_rs1_rdy;
    logic             issue_rs2_rdy;
    logic [31:0]      issue_rs1_val;
    logic [31:0]      issue_rs2_val;
    logic [ROB_W-1:0] issue_rs1_tag;
    logic [ROB_W-1:0] issue_rs2_tag;
    logic [31:0]      issue_imm;
    logic [31:0]      issue_pc;
    logic             rs_full;

    // result broadcast buses
    logic             alu_result;
    logic [ROB_W-1:0] alu_result_rob_pos;
    logic [31:0]      alu_result_val;
    logic             lsb_result;
    logic [ROB_W-1:0] lsb_result_rob_pos;
    logic [31:0]      lsb_result_val;

    // dispatch port into the ALU
    logic             alu_en;
    logic [6:0]       alu_opcode;
    logic [2:0]       alu_funct3;
    logic             alu_funct7;
    logic [31:0]      alu_val1;
    logic [31:0]      alu_val2;
    logic [31:0]      alu_imm;
    logic [31:0]      alu_pc;
    logic [ROB_W-1:0] alu_rob_pos;

    // issue logic / result producers / ALU side
    modport master (
        output issue_en, issue_rob_pos, issue_opcode, issue_funct3, issue_funct7,
               issue_rs1_rdy, issue_rs2_rdy, issue_rs1_val, issue_rs2_val,
               issue_rs1_tag, issue_rs2_tag, issue_imm, issue_pc,
               alu_result, alu_result_rob_pos, alu_result_val,
               lsb_result, lsb_result_rob_pos, lsb_result_val,
        input  rs_full, alu_en, alu_opcode, alu_funct3, alu_funct7,
               alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_pos
    );

    // reservation station side
    modport slave (
        input  issue_en, issue_rob_pos, issue_opcode, issue_funct3, issue_funct7,
               issue_rs1_rdy, issue_rs2_rdy, issue_rs1_val, issue_rs2_val,
               issue_rs1_tag, issue_rs2_tag, issue_imm, issue_pc,
               alu_result, alu_result_rob_pos, alu_result_val,
               lsb_result, lsb_result_rob_pos, lsb_result_val,
        output rs_full, alu_en, alu_opcode, alu_funct3, alu_funct7,
               alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_pos
    );
endinterface

// File: rtl/rs_alu.sv
// Reservation station for the integer ALU: buffers issued micro-ops, wakes
// their operands from the ALU/LSB broadcast buses and dispatches the
// lowest-index fully ready entry each cycle.
module rs_alu #(
    parameter int RS_SIZE = 16,
    parameter int ROB_W   = 4
) (
    input logic        clk,
    input logic        rst,
    input logic        rdy,
    input logic        rollback,
    rs_alu_if.slave    bus
);
    localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

    typedef struct packed {
        logic             busy;
        logic [6:0]       opcode;
        logic [2:0]       funct3;
        logic             funct7;
        logic             rdy1;
        logic [31:0]      val1;
        logic [ROB_W-1:0] tag1;
        logic             rdy2;
        logic [31:0]      val2;
        logic [ROB_W-1:0] tag2;
        logic [31:0]      imm;
        logic [31:0]      pc;
        logic [ROB_W-1:0] rob_pos;
    } entry_t;

    typedef struct packed {
        logic [6:0]       opcode;
        logic [2:0]       funct3;
        logic             funct7;
        logic [31:0]      val1;
        logic [31:0]      val2;
        logic [31:0]      imm;
        logic [31:0]      pc;
        logic [ROB_W-1:0] rob_pos;
    } disp_t;

    entry_t             ent_q [RS_SIZE];
    entry_t             ent_d [RS_SIZE];
    disp_t              disp_q, disp_d;
    logic               alu_en_q, alu_en_d;
    logic [RS_SIZE-1:0] busy_vec;
    logic               full;
    logic [IDX_W-1:0]   free_idx, disp_idx;
    logic               free_found, disp_found;

    // Operand capture from the broadcast buses; the ALU bus takes precedence.
    function automatic logic [32:0] snoop(
        input logic             r,
        input logic [31:0]      v,
        input logic [ROB_W-1:0] t,
        input logic             a_en,
        input logic [ROB_W-1:0] a_tag,
        input logic [31:0]      a_val,
        input logic             l_en,
        input logic [ROB_W-1:0] l_tag,
        input logic [31:0]      l_val
    );
        logic [32:0] res;
        res = {r, v};
        if (!r) begin
            if (a_en && (a_tag == t)) begin
                res = {1'b1, a_val};
            end else if (l_en && (l_tag == t)) begin
                res = {1'b1, l_val};
            end
        end
        return res;
    endfunction

    // Busy vector of the registered entries drives rs_full.
    always_comb begin
        busy_vec = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            busy_vec[i] = ent_q[i].busy;
        end
    end

    assign full = &busy_vec;

    // Lowest-index free slot and lowest-index ready slot from pre-edge state.
    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        disp_idx   = '0;
        disp_found = 1'b0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (!ent_q[i].busy) begin
                if (!free_found) begin
                    free_idx   = IDX_W'(i);
                    free_found = 1'b1;
                end
            end else if (ent_q[i].rdy1 && ent_q[i].rdy2 && !disp_found) begin
                disp_idx   = IDX_W'(i);
                disp_found = 1'b1;
            end
        end
    end

    // Next state: rollback flush, else wakeup, dispatch and allocation.
    always_comb begin
        logic [32:0] op1, op2;
        ent_d    = ent_q;
        disp_d   = disp_q;
        alu_en_d = 1'b0;
        op1      = '0;
        op2      = '0;
        if (rollback) begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                ent_d[i].busy = 1'b0;
            end
            disp_d = '0;
        end else begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                if (ent_q[i].busy) begin
                    op1 = snoop(ent_q[i].rdy1, ent_q[i].val1, ent_q[i].tag1,
                                bus.alu_result, bus.alu_result_rob_pos, bus.alu_result_val,
                                bus.lsb_result, bus.lsb_result_rob_pos, bus.lsb_result_val);
                    op2 = snoop(ent_q[i].rdy2, ent_q[i].val2, ent_q[i].tag2,
                                bus.alu_result, bus.alu_result_rob_pos, bus.alu_result_val,
                                bus.lsb_result, bus.lsb_result_rob_pos, bus.lsb_result_val);
                    ent_d[i].rdy1 = op1[32];
                    ent_d[i].val1 = op1[31:0];
                    ent_d[i].rdy2 = op2[32];
                    ent_d[i].val2 = op2[31:0];
                end
            end

            if (disp_found) begin
                alu_en_d        = 1'b1;
                disp_d.opcode   = ent_q[disp_idx].opcode;
                disp_d.funct3   = ent_q[disp_idx].funct3;
                disp_d.funct7   = ent_q[disp_idx].funct7;
                disp_d.val1     = ent_q[disp_idx].val1;
                disp_d.val2     = ent_q[disp_idx].val2;
                disp_d.imm      = ent_q[disp_idx].imm;
                disp_d.pc       = ent_q[disp_idx].pc;
                disp_d.rob_pos  = ent_q[disp_idx].rob_pos;
                ent_d[disp_idx].busy = 1'b0;
            end

            // free_idx is a non-busy slot, so it never collides with the dispatched one
            if (bus.issue_en && !full) begin
                op1 = snoop(bus.issue_rs1_rdy, bus.issue_rs1_val, bus.issue_rs1_tag,
                            bus.alu_result, bus.alu_result_rob_pos, bus.alu_result_val,
                            bus.lsb_result, bus.lsb_result_rob_pos, bus.lsb_result_val);
                op2 = snoop(bus.issue_rs2_rdy, bus.issue_rs2_val, bus.issue_rs2_tag,
                            bus.alu_result, bus.alu_result_rob_pos, bus.alu_result_val,
                            bus.lsb_result, bus.lsb_result_rob_pos, bus.lsb_result_val);
                ent_d[free_idx].busy    = 1'b1;
                ent_d[free_idx].opcode  = bus.issue_opcode;
                ent_d[free_idx].funct3  = bus.issue_funct3;
                ent_d[free_idx].funct7  = bus.issue_funct7;
                ent_d[free_idx].rdy1    = op1[32];
                ent_d[free_idx].val1    = op1[31:0];
                ent_d[free_idx].tag1    = bus.issue_rs1_tag;
                ent_d[free_idx].rdy2    = op2[32];
                ent_d[free_idx].val2    = op2[31:0];
                ent_d[free_idx].tag2    = bus.issue_rs2_tag;
                ent_d[free_idx].imm     = bus.issue_imm;
                ent_d[free_idx].pc      = bus.issue_pc;
                ent_d[free_idx].rob_pos = bus.issue_rob_pos;
            end
        end
    end

    // State registers: synchronous reset, hold everything while rdy is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                ent_q[i] <= '0;
            end
            disp_q   <= '0;
            alu_en_q <= 1'b0;
        end else if (rdy) begin
            ent_q    <= ent_d;
            disp_q   <= disp_d;
            alu_en_q <= alu_en_d;
        end
    end

    assign bus.rs_full     = full;
    assign bus.alu_en      = alu_en_q;
    assign bus.alu_opcode  = disp_q.opcode;
    assign bus.alu_funct3  = disp_q.funct3;
    assign bus.alu_funct7  = disp_q.funct7;
    assign bus.alu_val1    = disp_q.val1;
    assign bus.alu_val2    = disp_q.val2;
    assign bus.alu_imm     = disp_q.imm;
    assign bus.alu_pc      = disp_q.pc;
    assign bus.alu_rob_pos = disp_q.rob_pos;
endmodule

// File: tb/tb_rs_alu.sv
// Bench for rs_alu: directed scenarios with literal expectations followed by
// randomized traffic, all checked against a behavioural model of the station.
module tb_rs_alu;
    localparam int RS = 16;
    localparam int RW = 4;

    logic clk = 1'b0;
    logic rst, rdy, rollback;

    always #5 clk = ~clk;

    rs_alu_if #(.ROB_W(RW)) bus ();

    rs_alu #(.RS_SIZE(RS), .ROB_W(RW)) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .rollback (rollback),
        .bus      (bus)
    );

    typedef struct {
        bit          busy;
        bit [6:0]    op;
        bit [2:0]    f3;
        bit          f7;
        bit          r1;
        bit [31:0]   v1;
        bit [RW-1:0] t1;
        bit          r2;
        bit [31:0]   v2;
        bit [RW-1:0] t2;
        bit [31:0]   imm;
        bit [31:0]   pc;
        bit [RW-1:0] rob;
    } ment_t;

    ment_t       m [RS];
    bit          e_en;
    bit [6:0]    e_op;
    bit [2:0]    e_f3;
    bit          e_f7;
    bit [31:0]   e_v1, e_v2, e_imm, e_pc;
    bit [RW-1:0] e_rob;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit model_full();
        bit f = 1'b1;
        for (int i = 0; i < RS; i++) if (!m[i].busy) f = 1'b0;
        return f;
    endfunction

    // An operand waiting on tag t picks up whichever bus carries t (ALU first).
    function automatic bit [32:0] resolve(input bit r, input bit [31:0] v, input bit [RW-1:0] t);
        if (r) return {1'b1, v};
        if (bus.alu_result && bus.alu_result_rob_pos == t) return {1'b1, bus.alu_result_val};
        if (bus.lsb_result && bus.lsb_result_rob_pos == t) return {1'b1, bus.lsb_result_val};
        return {1'b0, v};
    endfunction

    task automatic clear_outputs();
        e_en = 0; e_op = 0; e_f3 = 0; e_f7 = 0;
        e_v1 = 0; e_v2 = 0; e_imm = 0; e_pc = 0; e_rob = 0;
    endtask

    // Advance the model by one clock edge using the inputs presented before it.
    task automatic model_step();
        bit        was_full;
        int        fi, di;
        bit [32:0] o1, o2;
        if (rst) begin
            for (int i = 0; i < RS; i++) m[i].busy = 0;
            clear_outputs();
            return;
        end
        if (!rdy) return;
        if (rollback) begin
            for (int i = 0; i < RS; i++) m[i].busy = 0;
            clear_outputs();
            return;
        end
        was_full = model_full();
        fi = -1;
        di = -1;
        for (int i = 0; i < RS; i++) begin
            if (!m[i].busy && fi < 0) fi = i;
            if (m[i].busy && m[i].r1 && m[i].r2 && di < 0) di = i;
        end
        if (di >= 0) begin
            e_en = 1; e_op = m[di].op; e_f3 = m[di].f3; e_f7 = m[di].f7;
            e_v1 = m[di].v1; e_v2 = m[di].v2; e_imm = m[di].imm;
            e_pc = m[di].pc; e_rob = m[di].rob;
            m[di].busy = 0;
        end else begin
            e_en = 0;
        end
        for (int i = 0; i < RS; i++) begin
            if (m[i].busy) begin
                o1 = resolve(m[i].r1, m[i].v1, m[i].t1);
                o2 = resolve(m[i].r2, m[i].v2, m[i].t2);
                {m[i].r1, m[i].v1} = o1;
                {m[i].r2, m[i].v2} = o2;
            end
        end
        if (bus.issue_en && !was_full) begin
            o1 = resolve(bus.issue_rs1_rdy, bus.issue_rs1_val, bus.issue_rs1_tag);
            o2 = resolve(bus.issue_rs2_rdy, bus.issue_rs2_val, bus.issue_rs2_tag);
            m[fi].busy = 1; m[fi].op = bus.issue_opcode; m[fi].f3 = bus.issue_funct3;
            m[fi].f7 = bus.issue_funct7;
            {m[fi].r1, m[fi].v1} = o1; m[fi].t1 = bus.issue_rs1_tag;
            {m[fi].r2, m[fi].v2} = o2; m[fi].t2 = bus.issue_rs2_tag;
            m[fi].imm = bus.issue_imm; m[fi].pc = bus.issue_pc; m[fi].rob = bus.issue_rob_pos;
        end
    endtask

    // One clock: edge, settle, update model, compare every output.
    task automatic do_cycle();
        @(posedge clk);
        #1;
        model_step();
        chk("rs_full", bus.rs_full, model_full());
        chk("alu_en", bus.alu_en, e_en);
        chk("alu_opcode", bus.alu_opcode, e_op);
        chk("alu_funct3", bus.alu_funct3, e_f3);
        chk("alu_funct7", bus.alu_funct7, e_f7);
        chk("alu_val1", bus.alu_val1, e_v1);
        chk("alu_val2", bus.alu_val2, e_v2);
        chk("alu_imm", bus.alu_imm, e_imm);
        chk("alu_pc", bus.alu_pc, e_pc);
        chk("alu_rob_pos", bus.alu_rob_pos, e_rob);
    endtask

    task automatic clear_in();
        rst = 0; rdy = 1; rollback = 0;
        bus.issue_en = 0; bus.issue_rob_pos = 0; bus.issue_opcode = 0;
        bus.issue_funct3 = 0; bus.issue_funct7 = 0;
        bus.issue_rs1_rdy = 0; bus.issue_rs2_rdy = 0;
        bus.issue_rs1_val = 0; bus.issue_rs2_val = 0;
        bus.issue_rs1_tag = 0; bus.issue_rs2_tag = 0;
        bus.issue_imm = 0; bus.issue_pc = 0;
        bus.alu_result = 0; bus.alu_result_rob_pos = 0; bus.alu_result_val = 0;
        bus.lsb_result = 0; bus.lsb_result_rob_pos = 0; bus.lsb_result_val = 0;
    endtask

    task automatic set_issue(input bit [RW-1:0] rob, input bit [6:0] op,
                             input bit r1, input bit [31:0] v1, input bit [RW-1:0] t1,
                             input bit r2, input bit [31:0] v2, input bit [RW-1:0] t2,
                             input bit [31:0] imm, input bit [31:0] pc);
        bus.issue_en = 1; bus.issue_rob_pos = rob; bus.issue_opcode = op;
        bus.issue_funct3 = 3'd0; bus.issue_funct7 = 1'b0;
        bus.issue_rs1_rdy = r1; bus.issue_rs1_val = v1; bus.issue_rs1_tag = t1;
        bus.issue_rs2_rdy = r2; bus.issue_rs2_val = v2; bus.issue_rs2_tag = t2;
        bus.issue_imm = imm; bus.issue_pc = pc;
    endtask

    localparam bit [6:0] OP_ADDI = 7'b0010011;
    localparam bit [6:0] OP_ADD  = 7'b0110011;

    initial begin
        clear_in();
        clear_outputs();

        // reset for two cycles
        rst = 1;
        do_cycle();
        do_cycle();
        chk("lit_reset_en", bus.alu_en, 1'b0);
        chk("lit_reset_full", bus.rs_full, 1'b0);
        chk("lit_reset_val1", bus.alu_val1, 32'h0);
        chk("lit_reset_rob", bus.alu_rob_pos, 32'h0);
        clear_in();

        // ready ADDI: dispatch two edges after issue, exactly one pulse
        set_issue(4'd3, OP_ADDI, 1, 32'd5, 0, 1, 0, 0, 32'd7, 32'h100);
        do_cycle();
        chk("lit_addi_e1_en", bus.alu_en, 1'b0);
        clear_in();
        do_cycle();
        chk("lit_addi_en", bus.alu_en, 1'b1);
        chk("lit_addi_val1", bus.alu_val1, 32'd5);
        chk("lit_addi_imm", bus.alu_imm, 32'd7);
        chk("lit_addi_rob", bus.alu_rob_pos, 32'd3);
        do_cycle();
        chk("lit_addi_pulse_end", bus.alu_en, 1'b0);

        // wakeup from the LSB bus three cycles after issue
        set_issue(4'd8, OP_ADD, 0, 0, 4'd6, 1, 32'd1, 0, 0, 32'h200);
        do_cycle();
        clear_in();
        do_cycle();
        do_cycle();
        bus.lsb_result = 1; bus.lsb_result_rob_pos = 4'd6; bus.lsb_result_val = 32'h10;
        do_cycle();
        chk("lit_wake_e0_en", bus.alu_en, 1'b0);
        clear_in();
        do_cycle();
        chk("lit_wake_en", bus.alu_en, 1'b1);
        chk("lit_wake_val1", bus.alu_val1, 32'h10);

        // same-cycle bypass from the ALU bus
        set_issue(4'd9, OP_ADD, 1, 32'd4, 0, 0, 0, 4'd2, 0, 32'h300);
        bus.alu_result = 1; bus.alu_result_rob_pos = 4'd2; bus.alu_result_val = 32'd9;
        do_cycle();
        clear_in();
        do_cycle();
        chk("lit_bypass_en", bus.alu_en, 1'b1);
        chk("lit_bypass_val2", bus.alu_val2, 32'd9);

        // fill all entries waiting on tag 1, then drain in index order
        for (int i = 0; i < RS; i++) begin
            set_issue(RW'(i), OP_ADD, 0, 0, 4'd1, 1, 32'd2, 0, 32'(i), 32'(i * 4));
            do_cycle();
        end
        chk("lit_fill_full", bus.rs_full, 1'b1);
        set_issue(4'd12, OP_ADDI, 1, 32'd77, 0, 1, 0, 0, 0, 0);  // dropped while full
        do_cycle();
        clear_in();
        bus.alu_result = 1; bus.alu_result_rob_pos = 4'd1; bus.alu_result_val = 32'hAB;
        do_cycle();
        clear_in();
        for (int i = 0; i < RS; i++) begin
            do_cycle();
            chk("lit_drain_en", bus.alu_en, 1'b1);
            chk("lit_drain_rob", bus.alu_rob_pos, 32'(i));
            chk("lit_drain_val1", bus.alu_val1, 32'hAB);
            if (i == 0) chk("lit_drain_full", bus.rs_full, 1'b0);
        end
        do_cycle();
        chk("lit_drain_done", bus.alu_en, 1'b0);

        // rollback discards waiting entries and the one about to dispatch
        for (int i = 0; i < 4; i++) begin
            set_issue(RW'(i), OP_ADD, 0, 0, 4'd5, 1, 0, 0, 0, 0);
            do_cycle();
        end
        set_issue(4'd4, OP_ADDI, 1, 32'd3, 0, 1, 0, 0, 32'd1, 0);
        do_cycle();
        clear_in();
        rollback = 1;
        do_cycle();
        chk("lit_rb_en", bus.alu_en, 1'b0);
        chk("lit_rb_full", bus.rs_full, 1'b0);
        chk("lit_rb_val1", bus.alu_val1, 32'h0);
        clear_in();
        bus.lsb_result = 1; bus.lsb_result_rob_pos = 4'd5; bus.lsb_result_val = 32'h55;
        do_cycle();
        clear_in();
        do_cycle();
        chk("lit_rb_nodisp", bus.alu_en, 1'b0);
        do_cycle();
        chk("lit_rb_nodisp2", bus.alu_en, 1'b0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            clear_in();
            rst      = ($urandom_range(0, 499) == 0);
            rdy      = ($urandom_range(0, 7) != 0);
            rollback = ($urandom_range(0, 63) == 0);
            if ((!model_full() && $urandom_range(0, 1) == 1) || $urandom_range(0, 31) == 0) begin
                set_issue(RW'($urandom_range(0, 15)), 7'($urandom),
                          1'($urandom_range(0, 2) == 0), $urandom, RW'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), $urandom, RW'($urandom_range(0, 3)),
                          $urandom, $urandom);
                bus.issue_funct3 = 3'($urandom);
                bus.issue_funct7 = 1'($urandom);
            end
            if ($urandom_range(0, 2) == 0) begin
                bus.alu_result = 1;
                bus.alu_result_rob_pos = RW'($urandom_range(0, 3));
                bus.alu_result_val = $urandom;
            end
            if ($urandom_range(0, 2) == 0) begin
                bus.lsb_result = 1;
                bus.lsb_result_rob_pos = RW'($urandom_range(0, 3));
                bus.lsb_result_val = $urandom;
            end
            do_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
